// File: rtl/config_write_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_write_if : valid/ready word stream into the configuration frame writer
// Revision 1.0
// ---------------------------------------------------------------------------
interface config_write_if;
    logic [31:0] WriteData;
    logic        WriteValid;
    logic        WriteReady;

    modport master (output WriteData, output WriteValid, input  WriteReady);
    modport slave  (input  WriteData, input  WriteValid, output WriteReady);
endinterface
`default_nettype wire

// File: rtl/config_frame_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_frame_writer : header + row words -> per-row frame data, one column/frame strobe
// Revision 1.0
// ---------------------------------------------------------------------------
module config_frame_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 4,
    parameter int NumberOfCols    = 8
) (
    input  wire logic                                  CLK,
    input  wire logic                                  RST,
    config_write_if.slave                              wr,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]    FrameStrobe,
    output logic                                       Busy,
    output logic                                       HeaderError,
    output logic                                       RangeError,
    output logic [15:0]                                FramesWritten
);
    localparam int              ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);
    localparam logic [7:0]      SYNC     = 8'hA5;
    localparam logic [8:0]      COLS_LIM = 9'(NumberOfCols);
    localparam logic [8:0]      FRMS_LIM = 9'(MaxFramesPerCol);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        col;
    logic [7:0]        frame;
    logic [ROW_W-1:0]  row;
    logic [15:0]       frames_cnt;
    logic              header_err;
    logic              xfer;
    logic              sync_ok;
    logic              in_range;

    assign wr.WriteReady = (state == IDLE) || (state == LOAD);
    assign xfer          = wr.WriteValid && wr.WriteReady;
    assign sync_ok       = (wr.WriteData[31:24] == SYNC);
    assign in_range      = ({1'b0, col} < COLS_LIM) && ({1'b0, frame} < FRMS_LIM);
    assign Busy          = (state != IDLE);
    assign RangeError    = (state == STROBE) && !in_range;
    assign HeaderError   = header_err;
    assign FramesWritten = frames_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer && sync_ok)         state_next = LOAD;
            LOAD:    if (xfer && row == LAST_ROW) state_next = STROBE;
            STROBE:                               state_next = GAP;
            GAP:                                  state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Strobe is decoded straight from the latched address so it can only exist in STROBE.
    always_comb begin
        FrameStrobe = '0;
        if (state == STROBE && in_range) begin
            for (int c = 0; c < NumberOfCols; c++) begin
                for (int f = 0; f < MaxFramesPerCol; f++) begin
                    if (col == 8'(c) && frame == 8'(f)) begin
                        FrameStrobe[c*MaxFramesPerCol + f] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col        <= '0;
            frame      <= '0;
            row        <= '0;
            FrameData  <= '0;
            frames_cnt <= '0;
            header_err <= 1'b0;
        end else begin
            header_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (sync_ok) begin
                            col   <= wr.WriteData[23:16];
                            frame <= wr.WriteData[15:8];
                            row   <= '0;
                        end else begin
                            header_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= wr.WriteData[FrameBitsPerRow-1:0];
                        row <= row + ROW_W'(1);
                    end
                end
                STROBE: begin
                    if (in_range) begin
                        frames_cnt <= frames_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_config_frame_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_config_frame_writer : randomized frame traffic against a frame-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_config_frame_writer;
    localparam int FB = 32;
    localparam int MF = 20;
    localparam int NR = 4;
    localparam int NC = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    config_write_if wif();

    logic [NR*FB-1:0] FrameData;
    logic [NC*MF-1:0] FrameStrobe;
    logic             Busy;
    logic             HeaderError;
    logic             RangeError;
    logic [15:0]      FramesWritten;

    config_frame_writer #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .NumberOfRows    (NR),
        .NumberOfCols    (NC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .wr            (wif),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .Busy          (Busy),
        .HeaderError   (HeaderError),
        .RangeError    (RangeError),
        .FramesWritten (FramesWritten)
    );

    int          errors = 0;
    int          checks = 0;
    logic [NR*FB-1:0] m_fd;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic xfer(input logic [31:0] d, input bit rnd);
        bit done = 0;
        int n = 0;
        while (!done && n < 200) begin
            wif.WriteData  = d;
            wif.WriteValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = wif.WriteValid && wif.WriteReady;
            @(negedge CLK);
            n++;
        end
        wif.WriteValid = 1'b0;
        if (!done) check("xfer_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] f,
                              input logic [31:0] rows [NR], input bit rnd);
        logic [NC*MF-1:0] exp_s = '0;
        bit ok;
        xfer({8'hA5, c, f, 8'($urandom)}, rnd);
        for (int r = 0; r < NR; r++) begin
            xfer(rows[r], rnd);
            m_fd[r*FB +: FB] = rows[r];
        end
        ok = (int'(c) < NC) && (int'(f) < MF);
        if (ok) begin
            exp_s[int'(c)*MF + int'(f)] = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
        end
        check("strobe_vec", FrameStrobe, exp_s);
        check("range_err", RangeError, !ok);
        check("hdr_err_strobe", HeaderError, 0);
        check("fd_strobe", FrameData, m_fd);
        check("ready_strobe", wif.WriteReady, 0);
        @(negedge CLK);
        check("strobe_gap", FrameStrobe, 0);
        check("range_err_gap", RangeError, 0);
        check("fd_gap", FrameData, m_fd);
        check("ready_gap", wif.WriteReady, 0);
        check("frames_written", FramesWritten, 16'(m_cnt));
        @(negedge CLK);
        check("ready_idle", wif.WriteReady, 1);
        check("busy_idle", Busy, 0);
    endtask

    task automatic bad_header(input logic [7:0] s);
        xfer({s, 8'($urandom), 8'($urandom), 8'($urandom)}, 0);
        check("hdr_err_pulse", HeaderError, 1);
        check("hdr_busy", Busy, 0);
        check("hdr_fd_hold", FrameData, m_fd);
        @(negedge CLK);
        check("hdr_err_clear", HeaderError, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_fd", FrameData, 0);
        check("rst_strobe", FrameStrobe, 0);
        check("rst_cnt", FramesWritten, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready", wif.WriteReady, 1);
        check("rst_errs", {HeaderError, RangeError}, 0);
        m_fd  = '0;
        m_cnt = 0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] rows [NR];
        logic [7:0]  s;
        wif.WriteValid = 1'b0;
        wif.WriteData  = '0;
        m_fd  = '0;
        m_cnt = 0;
        @(negedge CLK);
        do_reset();

        rows = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_frame(8'd3, 8'd5, rows, 0);
        check("fd_known", FrameData, 128'h44444444_33333333_22222222_11111111);

        bad_header(8'h5A);
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd1, 8'd2, rows, 0);

        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd8, 8'd21, rows, 0);

        // Reset in the middle of a frame must discard it.
        xfer({8'hA5, 8'd4, 8'd6, 8'h00}, 0);
        xfer(32'hDEADBEEF, 0);
        xfer(32'hCAFEF00D, 0);
        RST = 1'b1;
        #1;
        check("mid_rst_fd", FrameData, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_strobe", FrameStrobe, 0);
        check("mid_rst_ready", wif.WriteReady, 1);
        RST = 1'b0;
        @(negedge CLK);
        m_fd  = '0;
        m_cnt = 0;
        check("post_rst_strobe", FrameStrobe, 0);
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd6, 8'd3, rows, 0);

        do_reset();
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd0, 8'd0, rows, 1);
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd7, 8'd19, rows, 1);
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd2, 8'd10, rows, 1);
        check("three_frames", FramesWritten, 16'd3);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                s = 8'hA5;
                while (s == 8'hA5) s = 8'($urandom);
                bad_header(s);
            end else begin
                for (int r = 0; r < NR; r++) rows[r] = $urandom;
                send_frame(8'($urandom_range(0, 9)), 8'($urandom_range(0, 23)), rows,
                           1'($urandom_range(0, 1)));
            end
        end

        force dut.frames_cnt = 16'hFFFF;
        #1;
        release dut.frames_cnt;
        m_cnt = 65535;
        check("cnt_preload", FramesWritten, 16'hFFFF);
        @(negedge CLK);
        for (int r = 0; r < NR; r++) rows[r] = $urandom;
        send_frame(8'd1, 8'd1, rows, 0);
        check("cnt_wrap", FramesWritten, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
